// File: rtl/imem_fetch.sv
// Instruction memory with 1-cycle synchronous read, stall/flush,
// address checking and a word-streaming program load port.
module imem_fetch #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 1024,
  parameter              INIT_FILE   = "code.txt"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        addr_err
);

  localparam int W = $clog2(DEPTH_WORDS);
  localparam logic [W-1:0] LAST = W'(DEPTH_WORDS - 1);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t      state;
  logic [W-1:0] cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]  offs;
  logic [W-1:0] idx;
  logic         err;
  logic         run;
  logic         wr_en;

  // Word offset from the base; wrap of the subtraction is caught
  // by the explicit below-base test.
  assign offs  = pc - ADDR_BASE;
  assign idx   = offs[W+1:2];
  assign err   = (pc[1:0] != 2'b00)
              || (pc < ADDR_BASE)
              || ((offs >> 2) >= 32'(DEPTH_WORDS));
  assign run   = (state == RUN);
  assign wr_en = (state == LOAD) && load_valid;

  assign load_ready = (state == LOAD);

  // Program store: never reset so a loaded image survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt] <= load_data;
    end
  end

  // Load FSM plus the registered fetch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      load_done   <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      load_done <= 1'b0;

      unique case (state)
        RUN: begin
          if (load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (load_last || cnt == LAST) begin
              state     <= RUN;
              cnt       <= '0;
              load_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase

      if (flush) begin
        instr       <= '0;
        instr_valid <= 1'b0;
        addr_err    <= 1'b0;
      end else if (stall && run) begin
        instr       <= instr;
        instr_valid <= instr_valid;
        addr_err    <= addr_err;
      end else if (run && fetch_en) begin
        instr       <= err ? 32'h0 : mem[idx];
        instr_valid <= 1'b1;
        addr_err    <= err;
      end else begin
        instr       <= '0;
        instr_valid <= 1'b0;
        addr_err    <= 1'b0;
      end
    end
  end

endmodule
